// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial-in / parallel-out receiver.
package shift_reg_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Receiver FSM: IDLE holds no partial bits, SHIFT has 1..WIDTH-1 captured.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit counter width; the count only ever reaches WIDTH-1 before wrapping.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/shift_register_sipo.sv
// Serial-in / parallel-out receiver. MSB-first words are assembled in a shift
// register; completed words land in po with a valid/ack handshake and a sticky
// overrun flag when an unacknowledged word is overwritten.
module shift_register_sipo
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             si,
  input  logic             ack,
  output logic [WIDTH-1:0] po,
  output logic             valid,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;

  // Next-state: ack clears the handshake first, then a completing word
  // overrides po/valid/overrun so a same-edge ack still yields a fresh word.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    po_d      = po_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    if (on) begin
      sr_d = {sr_q[WIDTH-2:0], si};
      if (cnt_q == LAST) begin
        // Word complete: hand it off and restart from bit 1 next edge.
        state_d   = IDLE;
        cnt_d     = '0;
        sr_d      = '0;
        po_d      = {sr_q[WIDTH-2:0], si};
        valid_d   = 1'b1;
        overrun_d = valid_q && !ack;
      end else begin
        state_d = SHIFT;
        cnt_d   = cnt_q + CW'(1);
      end
    end else begin
      // Dropping on aborts any partial word; the output side is untouched.
      state_d = IDLE;
      cnt_d   = '0;
      sr_d    = '0;
    end

    busy_d = (cnt_d != '0);
  end

  // State and registered outputs; reset wins over on/ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      po_q      <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      po_q      <= po_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign po      = po_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
  assign busy    = busy_q;

endmodule
